// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface definitions: command codes, default widths and
// the arbiter's state encoding.
package mem_arbiter_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_CMD_WIDTH     = 1;

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: prio breaks ties, otherwise the
// single valid requester wins.
module rr_pick2 (
    input  logic valid0,
    input  logic valid1,
    input  logic prio,
    output logic grant_valid,
    output logic grant_idx
);

    assign grant_valid = valid0 | valid1;
    assign grant_idx   = (valid0 && valid1) ? prio : valid1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory; one transaction
// outstanding, response routed back to the port that issued it.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int CMD_WIDTH     = DEFAULT_CMD_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     r0_valid,
    input  logic                     r1_valid,
    output logic                     r0_ready,
    output logic                     r1_ready,
    input  logic [ADDRESS_WIDTH-1:0] r0_address,
    input  logic [ADDRESS_WIDTH-1:0] r1_address,
    input  logic [CMD_WIDTH-1:0]     r0_cmd,
    input  logic [CMD_WIDTH-1:0]     r1_cmd,
    input  logic [DATA_WIDTH-1:0]    r0_data,
    input  logic [DATA_WIDTH-1:0]    r1_data,
    output logic                     r0_res_valid,
    output logic                     r1_res_valid,
    input  logic                     r0_res_ready,
    input  logic                     r1_res_ready,
    output logic [DATA_WIDTH-1:0]    r0_res_data,
    output logic [DATA_WIDTH-1:0]    r1_res_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [ADDRESS_WIDTH-1:0] m_address,
    output logic [CMD_WIDTH-1:0]     m_cmd,
    output logic [DATA_WIDTH-1:0]    m_data,
    input  logic                     m_res_valid,
    output logic                     m_res_ready,
    input  logic [DATA_WIDTH-1:0]    m_res_data
);

    arb_state_t               state_reg, state_next;
    logic                     prio_reg;
    logic                     owner_reg;
    logic [ADDRESS_WIDTH-1:0] address_reg;
    logic [CMD_WIDTH-1:0]     cmd_reg;
    logic [DATA_WIDTH-1:0]    data_reg;

    logic                     grant_valid;
    logic                     grant_idx;
    logic                     in_idle, in_issue, in_wait;
    logic                     accept, res_done;
    logic [NUM_PORTS-1:0]     res_ready_vec;
    logic [NUM_PORTS-1:0]     res_valid_vec;
    logic [DATA_WIDTH-1:0]    res_data_vec [NUM_PORTS];

    rr_pick2 u_pick (
        .valid0      (r0_valid),
        .valid1      (r1_valid),
        .prio        (prio_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Qualifying every state decode with reset forces all outputs low while
    // reset is held, even before the first clock edge has cleared state_reg.
    assign in_idle  = reset && (state_reg == IDLE);
    assign in_issue = reset && (state_reg == ISSUE);
    assign in_wait  = reset && (state_reg == WAIT);

    assign accept   = in_idle && grant_valid;
    assign r0_ready = accept && !grant_idx;
    assign r1_ready = accept && grant_idx;

    assign m_valid   = in_issue;
    assign m_address = in_issue ? address_reg : '0;
    assign m_cmd     = in_issue ? cmd_reg : '0;
    assign m_data    = in_issue ? data_reg : '0;

    assign res_ready_vec = {r1_res_ready, r0_res_ready};
    assign m_res_ready   = in_wait && res_ready_vec[owner_reg];
    assign res_done      = m_res_valid && m_res_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign res_valid_vec[gi] = in_wait && (owner_reg == 1'(gi)) && m_res_valid;
            assign res_data_vec[gi]  = res_valid_vec[gi] ? m_res_data : '0;
        end
    endgenerate

    assign r0_res_valid = res_valid_vec[0];
    assign r1_res_valid = res_valid_vec[1];
    assign r0_res_data  = res_data_vec[0];
    assign r1_res_data  = res_data_vec[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            prio_reg    <= 1'b0;
            owner_reg   <= 1'b0;
            address_reg <= '0;
            cmd_reg     <= '0;
            data_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg   <= grant_idx;
                address_reg <= grant_idx ? r1_address : r0_address;
                cmd_reg     <= grant_idx ? r1_cmd : r0_cmd;
                data_reg    <= grant_idx ? r1_data : r0_data;
            end
            // The port just served loses the next tie.
            if (res_done) begin
                prio_reg <= ~owner_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   if (m_ready)     state_next = WAIT;
            WAIT:    if (res_done)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model checked
// every cycle, memory responder, and directed scenarios with literal expectations.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [31:0] r0_address, r1_address;
    logic        r0_cmd, r1_cmd;
    logic [31:0] r0_data, r1_data;
    logic        r0_res_valid, r1_res_valid, r0_res_ready, r1_res_ready;
    logic [31:0] r0_res_data, r1_res_data;
    logic        m_valid, m_ready;
    logic [31:0] m_address;
    logic        m_cmd;
    logic [31:0] m_data;
    logic        m_res_valid, m_res_ready;
    logic [31:0] m_res_data;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_address(r0_address), .r1_address(r1_address),
        .r0_cmd(r0_cmd), .r1_cmd(r1_cmd),
        .r0_data(r0_data), .r1_data(r1_data),
        .r0_res_valid(r0_res_valid), .r1_res_valid(r1_res_valid),
        .r0_res_ready(r0_res_ready), .r1_res_ready(r1_res_ready),
        .r0_res_data(r0_res_data), .r1_res_data(r1_res_data),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_address(m_address), .m_cmd(m_cmd), .m_data(m_data),
        .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
        .m_res_data(m_res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
    } resp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mem_lat  = 2;
    int          stall_n  = 0;
    int          grant_q[$];
    int          grant_cyc_q[$];
    logic [31:0] maddr_q[$];
    resp_t       resp_q[$];
    int          last_grant_cyc = 0;
    int          last_mv_rise   = 0;
    int          bp_cnt         = 0;
    int          stall_cnt      = 0;

    function automatic logic [31:0] mem_reply(logic [31:0] a, logic c, logic [31:0] d);
        if (c == MEM_CMD_WRITE) return d;
        if (a == 32'h10) return 32'hDEADBEEF;
        return a ^ 32'hCAFE0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: m_ready withheld for stall_n cycles per request, response
    // mem_lat cycles after acceptance, held until taken; cleared by reset.
    initial begin : responder
        bit          hs_req, hs_res, stall_inc, rst_s, pend;
        int          cnt, stalled;
        logic [31:0] sa, sd, rdata;
        logic        sc;
        pend = 0; cnt = 0; stalled = 0; rdata = '0;
        m_ready = 1'b1; m_res_valid = 1'b0; m_res_data = '0;
        forever begin
            @(negedge clk);
            hs_req    = m_valid && m_ready;
            hs_res    = m_res_valid && m_res_ready;
            stall_inc = m_valid && !m_ready;
            rst_s     = reset;
            sa = m_address; sc = m_cmd; sd = m_data;
            @(posedge clk);
            #1;
            if (!rst_s) begin
                pend = 0; stalled = 0;
                m_res_valid = 1'b0; m_res_data = '0;
            end else begin
                if (hs_res) begin
                    m_res_valid = 1'b0; m_res_data = '0;
                end
                if (stall_inc) stalled++;
                if (hs_req) begin
                    stalled = 0; pend = 1; cnt = mem_lat - 1;
                    rdata = mem_reply(sa, sc, sd);
                end else if (pend && cnt > 0) begin
                    cnt--;
                end
                if (pend && cnt == 0) begin
                    m_res_valid = 1'b1; m_res_data = rdata; pend = 0;
                end
            end
            m_ready = (stalled >= stall_n);
        end
    end

    // Reference model: an optional single outstanding transaction plus the
    // preferred port; expected outputs are derived from it every cycle.
    task automatic model_loop();
        bit          busy = 0, issued = 0, n_busy, n_issued;
        int          owner = 0, prio = 0, n_owner, n_prio, g;
        logic [31:0] a = '0, d = '0, n_a, n_d;
        logic        c = 1'b0, n_c, rr, prev_mv = 1'b0;
        logic        e_r0_ready, e_r1_ready, e_mv, e_mrr, e_r0v, e_r1v;
        logic [31:0] e_ma, e_md, e_r0d, e_r1d;
        logic        e_mc;
        forever begin
            @(negedge clk);
            e_r0_ready = 0; e_r1_ready = 0; e_mv = 0; e_mrr = 0; e_r0v = 0; e_r1v = 0;
            e_ma = '0; e_md = '0; e_mc = 1'b0; e_r0d = '0; e_r1d = '0;
            n_busy = busy; n_issued = issued; n_owner = owner; n_prio = prio;
            n_a = a; n_c = c; n_d = d;
            if (!reset) begin
                n_busy = 0; n_prio = 0;
            end else if (!busy) begin
                g = -1;
                if (r0_valid && r1_valid) g = prio;
                else if (r0_valid) g = 0;
                else if (r1_valid) g = 1;
                if (g == 0) e_r0_ready = 1;
                if (g == 1) e_r1_ready = 1;
                if (g >= 0) begin
                    n_busy = 1; n_issued = 0; n_owner = g;
                    n_a = (g == 1) ? r1_address : r0_address;
                    n_c = (g == 1) ? r1_cmd : r0_cmd;
                    n_d = (g == 1) ? r1_data : r0_data;
                end
            end else if (!issued) begin
                e_mv = 1; e_ma = a; e_mc = c; e_md = d;
                if (m_ready) n_issued = 1;
            end else begin
                rr = (owner == 1) ? r1_res_ready : r0_res_ready;
                e_mrr = rr;
                if (owner == 0) begin
                    e_r0v = m_res_valid; e_r0d = m_res_valid ? m_res_data : '0;
                end else begin
                    e_r1v = m_res_valid; e_r1d = m_res_valid ? m_res_data : '0;
                end
                if (m_res_valid && rr) begin
                    n_busy = 0; n_prio = 1 - owner;
                end
            end
            chk("r0_ready", r0_ready, e_r0_ready);
            chk("r1_ready", r1_ready, e_r1_ready);
            chk("m_valid", m_valid, e_mv);
            chk("m_res_ready", m_res_ready, e_mrr);
            chk("r0_res_valid", r0_res_valid, e_r0v);
            chk("r1_res_valid", r1_res_valid, e_r1v);
            chk("r0_res_data", r0_res_data, e_r0d);
            chk("r1_res_data", r1_res_data, e_r1d);
            if (e_mv || !reset) begin
                chk("m_address", m_address, e_ma);
                chk("m_cmd", m_cmd, e_mc);
                chk("m_data", m_data, e_md);
            end
            // Event logs of what the DUT actually did, for the directed checks.
            if (r0_valid && r0_ready) begin grant_q.push_back(0); grant_cyc_q.push_back(cyc); last_grant_cyc = cyc; end
            if (r1_valid && r1_ready) begin grant_q.push_back(1); grant_cyc_q.push_back(cyc); last_grant_cyc = cyc; end
            if (m_valid && !prev_mv) last_mv_rise = cyc;
            prev_mv = m_valid;
            if (m_valid && m_ready) maddr_q.push_back(m_address);
            if (m_valid && !m_ready) stall_cnt++;
            if (m_res_valid && !m_res_ready) bp_cnt++;
            if (r0_res_valid && r0_res_ready) resp_q.push_back('{0, r0_res_data});
            if (r1_res_valid && r1_res_ready) resp_q.push_back('{1, r1_res_data});
            @(posedge clk);
            cyc++;
            busy = n_busy; issued = n_issued; owner = n_owner; prio = n_prio;
            a = n_a; c = n_c; d = n_d;
        end
    endtask

    task automatic issue(input int p, input logic [31:0] a, input logic c, input logic [31:0] d);
        int t = 0;
        bit done = 0;
        if (p == 0) begin r0_valid = 1; r0_address = a; r0_cmd = c; r0_data = d; end
        else        begin r1_valid = 1; r1_address = a; r1_cmd = c; r1_data = d; end
        while (!done && t < 300) begin
            @(negedge clk);
            if ((p == 0) ? r0_ready : r1_ready) done = 1;
            tick();
            t++;
        end
        if (p == 0) r0_valid = 0; else r1_valid = 0;
        if (!done) chk("issue_timeout", 32'(p), 32'hFFFFFFFF);
    endtask

    task automatic wait_resps(input int n);
        int t = 0;
        while (resp_q.size() < n && t < 300) begin
            tick();
            t++;
        end
        if (resp_q.size() < n) chk("resp_timeout", 32'(resp_q.size()), 32'(n));
    endtask

    initial begin : main
        int g0, a0, r0n, s0, b0, t;
        reset = 0;
        r0_valid = 0; r1_valid = 0;
        r0_address = '0; r1_address = '0; r0_cmd = 0; r1_cmd = 0;
        r0_data = '0; r1_data = '0;
        r0_res_ready = 1; r1_res_ready = 1;
        fork
            model_loop();
        join_none

        // Reset held 3 cycles with both ports requesting.
        mem_lat = 2;
        fork
            issue(0, 32'h0, MEM_CMD_READ, '0);
            issue(1, 32'h100, MEM_CMD_READ, '0);
            begin repeat (3) tick(); reset = 1; end
        join
        wait_resps(2);
        chk("rst_first_grant", 32'(grant_q[0]), 0);
        chk("rst_second_grant", 32'(grant_q[1]), 1);
        chk("rst_resp0_data", resp_q[0].data, 32'hCAFE0000);
        chk("rst_resp1_port", 32'(resp_q[1].port), 1);
        $display("txn reset: grants %0d,%0d", grant_q[0], grant_q[1]);

        // Contention with a 1-cycle memory: alternation at 3 cycles per transaction.
        mem_lat = 1;
        g0 = grant_q.size(); a0 = maddr_q.size(); r0n = resp_q.size();
        fork
            begin issue(0, 32'h0, MEM_CMD_READ, '0); issue(0, 32'h0, MEM_CMD_READ, '0); end
            begin issue(1, 32'h100, MEM_CMD_READ, '0); issue(1, 32'h100, MEM_CMD_READ, '0); end
        join
        wait_resps(r0n + 4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_grant", 32'(grant_q[g0+i]), 32'(i % 2));
            chk("cont_m_address", maddr_q[a0+i], (i % 2) ? 32'h100 : 32'h0);
            if (i > 0) chk("cont_spacing", 32'(grant_cyc_q[g0+i] - grant_cyc_q[g0+i-1]), 3);
            $display("txn contention %0d: port %0d addr %h", i, grant_q[g0+i], maddr_q[a0+i]);
        end

        // Single read on port 0.
        mem_lat = 2;
        r0n = resp_q.size();
        issue(0, 32'h10, MEM_CMD_READ, '0);
        wait_resps(r0n + 1);
        chk("read_port", 32'(resp_q[r0n].port), 0);
        chk("read_data", resp_q[r0n].data, 32'hDEADBEEF);
        chk("read_issue_latency", 32'(last_mv_rise - last_grant_cyc), 1);
        $display("txn read: port %0d data %h", resp_q[r0n].port, resp_q[r0n].data);

        // Port 1 write with response back-pressure for 4 cycles.
        r0n = resp_q.size(); b0 = bp_cnt;
        r1_res_ready = 0;
        issue(1, 32'h200, MEM_CMD_WRITE, 32'hA5A51234);
        t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (m_res_valid) break;
            t++;
        end
        chk("bp_resp_seen", 32'(m_res_valid), 1);
        repeat (4) @(posedge clk);
        #1;
        r1_res_ready = 1;
        wait_resps(r0n + 1);
        chk("bp_cycles", 32'(bp_cnt - b0), 4);
        chk("bp_resp_port", 32'(resp_q[r0n].port), 1);
        chk("bp_resp_data", resp_q[r0n].data, 32'hA5A51234);
        $display("txn backpressure: port %0d data %h", resp_q[r0n].port, resp_q[r0n].data);

        // Memory stalls 5 cycles per request; port 0 arrives during the stall.
        stall_n = 5;
        r0n = resp_q.size(); g0 = grant_q.size(); s0 = stall_cnt;
        fork
            issue(1, 32'h300, MEM_CMD_WRITE, 32'h12345678);
            begin repeat (2) tick(); issue(0, 32'h40, MEM_CMD_READ, '0); end
        join
        wait_resps(r0n + 2);
        stall_n = 0;
        chk("stall_cycles", 32'(stall_cnt - s0), 10);
        chk("stall_grant0", 32'(grant_q[g0]), 1);
        chk("stall_grant1", 32'(grant_q[g0+1]), 0);
        chk("stall_resp0", resp_q[r0n].data, 32'h12345678);
        chk("stall_resp1", resp_q[r0n+1].data, 32'hCAFE0040);
        $display("txn stall: responses %h %h", resp_q[r0n].data, resp_q[r0n+1].data);

        // Reset during WAIT on a port-1 read; the response must never appear.
        mem_lat = 6;
        r0n = resp_q.size();
        issue(1, 32'h500, MEM_CMD_READ, '0);
        tick(); tick();
        reset = 0;
        tick(); tick();
        reset = 1;
        g0 = grant_q.size();
        fork
            issue(0, 32'h600, MEM_CMD_READ, '0);
            issue(1, 32'h700, MEM_CMD_READ, '0);
        join
        wait_resps(r0n + 2);
        repeat (10) tick();
        chk("midrst_grant0", 32'(grant_q[g0]), 0);
        chk("midrst_resp_count", 32'(resp_q.size() - r0n), 2);
        chk("midrst_resp0", resp_q[r0n].data, 32'hCAFE0600);
        chk("midrst_resp1", resp_q[r0n+1].data, 32'hCAFE0700);
        $display("txn midreset: next grant port %0d", grant_q[g0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `memory` block between the instruction-fetch requester (port 0) and the load/store requester (port 1). It accepts one request at a time, forwards it over the memory valid/ready handshake, and returns the response only to the requester that issued it. Priority is round-robin, so neither port can starve the other. It sits between the CPU front end / LSU and `memory`, and has exactly one transaction outstanding at a time.

## Interface

- `ADDRESS_WIDTH`, 32, address width in bits
- `DATA_WIDTH`, 32, data width in bits
- `CMD_WIDTH`, 1, width of the memory command field (`MEM_CMD_READ`, `MEM_CMD_WRITE`)

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-low
- `r0_valid`, `r1_valid`  in  1  request valid, per port
- `r0_ready`, `r1_ready`  out  1  request accepted this cycle, per port
- `r0_address`, `r1_address`  in  ADDRESS_WIDTH  request address
- `r0_cmd`, `r1_cmd`  in  CMD_WIDTH  request command
- `r0_data`, `r1_data`  in  DATA_WIDTH  write data; ignored for reads
- `r0_res_valid`, `r1_res_valid`  out  1  response valid, per port
- `r0_res_ready`, `r1_res_ready`  in  1  requester can take the response
- `r0_res_data`, `r1_res_data`  out  DATA_WIDTH  response data
- `m_valid`  out  1  request to memory (`i_valid`)
- `m_ready`  in  1  memory accepts a request (`o_ready`)
- `m_address`  out  ADDRESS_WIDTH  to `i_address`
- `m_cmd`  out  CMD_WIDTH  to `i_cmd`
- `m_data`  out  DATA_WIDTH  to `i_data`
- `m_res_valid`  in  1  memory response valid (`o_res_valid`)
- `m_res_ready`  out  1  to `i_res_ready`
- `m_res_data`  in  DATA_WIDTH  from `o_data`

## Operation

- **States:** IDLE, ISSUE, WAIT.
- **Priority pointer `prio`:** 1 bit, names the preferred port.
- **IDLE**
  - Grant selection: if both ports are valid, grant `prio`. Otherwise grant whichever port is valid.
  - `rN_ready` = 1 combinationally, for the granted port only. Both are 0 when no port is valid.
  - On the handshake (`rN_valid & rN_ready`): latch address, cmd and data into registers, set `owner` = N, go to ISSUE.
- **ISSUE**
  - `m_valid` = 1, and `m_address`/`m_cmd`/`m_data` are driven from the latched registers.
  - On `m_valid & m_ready`, go to WAIT. Otherwise hold and keep all `m_*` outputs stable.
- **WAIT**
  - `m_valid` = 0.
  - `m_res_ready` = `r<owner>_res_ready`.
  - `r<owner>_res_valid` = `m_res_valid`, and `r<owner>_res_data` = `m_res_data`, both combinational pass-through.
  - On `m_res_valid & m_res_ready`: set `prio` = ~`owner`, go to IDLE.
- **Non-owner port:** `res_valid` = 0 at all times.
- **Writes:** complete only when memory returns its response; the response data is forwarded unchanged.
- **Data gating:** `rN_res_data` = 0 whenever `rN_res_valid` is 0.
- **Reset behaviour**
  - Reset returns to IDLE with `prio` = 0.
  - Every output is 0 during reset.
  - Reset applied mid-transaction abandons the transaction silently; no response is delivered.
- **Requests in other states:** a request asserted while the arbiter is in ISSUE or WAIT sees `rN_ready` = 0 and must hold until it is accepted.

## Timing

- **Request path:**
  - Cycle 0: request accepted in IDLE.
  - Cycle 1: `m_valid` first high.
  - Minimum arbitration overhead: 1 cycle.
- **Response path:** same cycle as `m_res_valid`, with zero added latency.
- **Back-to-back:** the response handshake occurs in cycle k, and the next request can be accepted in cycle k+1 (from IDLE).
- **Throughput:** at most one transaction per 3 cycles, plus the memory's own latency.
- **Simultaneous requests:** with both ports valid in IDLE, exactly one `rN_ready` is high, as selected by `prio`.
- **Back-pressure:** if `r<owner>_res_ready` = 0, `m_res_ready` = 0 and the arbiter stays in WAIT. Memory must hold its response.
- **Memory protocol rules:** `m_valid` never deasserts before `m_ready`. `m_res_ready` is 0 outside WAIT.

## Structure

- **Shared include (memory header):** `MEM_CMD_READ`/`MEM_CMD_WRITE`, the `ADDRESS_WIDTH`/`DATA_WIDTH` defaults and the state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2).
- **Sub-module:** one, `rr_pick2`. It is combinational round-robin selection taking (`valid0`, `valid1`, `prio`) and producing (`grant_valid`, `grant_idx`). Keeping it separate lets the arbiter later scale to N ports.

## Test plan

- **Reset:** hold `reset` = 0 for 3 cycles while both ports assert valid → all outputs are 0, and the first accept after release goes to port 0.
- **Single read on port 0:** address 0x10, memory with ready always 1 and a 2-cycle response of 0xDEADBEEF → `m_valid` high at cycle 1, `r0_res_valid` with 0xDEADBEEF, `r1_res_valid` stays 0.
- **Contention:** both ports request continuously, port 0 at address 0x0 and port 1 at address 0x100 → grants alternate 0,1,0,1 over 4 transactions, and the `m_address` sequence is 0x0, 0x100, 0x0, 0x100.
- **Response back-pressure:** port 1 write with `r1_res_ready` = 0 for 4 cycles → `m_res_ready` = 0 for those cycles, the state stays WAIT, and the response is delivered when `r1_res_ready` rises.
- **Memory stall:** `m_ready` = 0 for 5 cycles during ISSUE → `m_valid`, `m_address` and `m_data` are stable throughout, and a port 0 request arriving meanwhile sees `r0_ready` = 0.
- **Reset mid-transaction:** assert `reset` in WAIT → arbiter returns to IDLE with `prio` = 0, and no `res_valid` is seen on either port.
